pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth; WIDTH SHALL be an integer multiple of STAGES.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand transfer request.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH  first operand.
REQ-008 SHALL have port b  input  WIDTH  second operand.
REQ-009 SHALL have port sub  input  1  0: a+b; 1: a-b.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port sum  output  WIDTH  result modulo 2^WIDTH.
REQ-013 SHALL have port carry_out  output  1  carry from MSB; for sub, 1 means no borrow.
REQ-014 SHALL have port overflow  output  1  two's-complement signed overflow.
REQ-015 SHALL have port zero  output  1  sum equals 0.

Function
REQ-016 SHALL compute a + (sub ? ~b : b) + sub, split into STAGES slices of WIDTH/STAGES bits, one slice per stage, LSB slice first.
REQ-017 SHALL carry each slice's carry-out as the next stage's carry-in; unprocessed upper operand bits and sub travel with the data.
REQ-018 SHALL transfer input when in_valid && in_ready; output when out_valid && out_ready.
REQ-019 SHALL have latency exactly STAGES cycles from input transfer to out_valid with no backpressure.
REQ-020 SHALL sustain one transfer per cycle when out_ready is held 1.
REQ-021 SHALL advance stage k only if stage k+1 is empty or advancing (per-stage valid bits, bubble collapsing).
REQ-022 SHALL drive in_ready = !valid[0] || stage 0 advancing; in_ready SHALL NOT depend on in_valid.
REQ-023 SHALL hold sum, carry_out, overflow, zero, out_valid stable while out_valid && !out_ready.
REQ-024 SHALL, when full with out_ready=1 and in_valid=1 in the same cycle, accept and emit both without loss.
REQ-025 SHALL drive overflow = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), b' the effective (inverted-for-sub) operand.
REQ-026 SHALL treat outputs as don't-care when out_valid=0 except out_valid and in_ready.

Reset
REQ-027 SHALL, on reset, clear all stage valid bits; out_valid=0, in_ready=1 in the following cycle.
REQ-028 SHALL drive sum=0, carry_out=0, overflow=0, zero=0 after reset.
REQ-029 SHALL discard in-flight operations on reset mid-operation; none emerge afterwards.

Configuration
REQ-030 SHALL, with PIPELINED_ADDER_OVF_EN defined, compute overflow per REQ-025 and carry sign bits through the pipeline.
REQ-031 SHALL, without PIPELINED_ADDER_OVF_EN, tie overflow to 0 and omit sign-tracking registers.

Structure
REQ-032 SHALL place the default WIDTH/STAGES constants and the sub-mode encoding (ADD=0, SUB=1) in shared package alu_pkg.
REQ-033 SHALL implement one slice adder as sub-module adder_slice (SLICE_W-bit a, b, cin -> sum, cout), instantiated once per stage.

Verification
REQ-034 SHALL cover: WIDTH=32, a=b=32'hFFFFFFFF, sub=0 -> after 4 cycles sum=32'hFFFFFFFE, carry_out=1, overflow=0, zero=0.
REQ-035 SHALL cover: a=32'h7FFFFFFF, b=1, sub=0 -> sum=32'h80000000, overflow=1 (0 if macro undefined).
REQ-036 SHALL cover: a=5, b=5, sub=1 -> sum=0, zero=1, carry_out=1; a=0, b=1, sub=1 -> sum=32'hFFFFFFFF, carry_out=0.
REQ-037 SHALL cover: 8 back-to-back inputs, out_ready=0 for cycles 3-7 -> in_ready falls once 4 held, all 8 results in order, none duplicated.
REQ-038 SHALL cover: reset asserted with 3 ops in flight -> out_valid=0 next cycle, no stale results after release.
REQ-039 SHALL cover: WIDTH=16, STAGES=2, random 1000 ops with random backpressure -> matches reference model every transfer.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the adder datapath: default geometry and the add/sub mode encoding.
package alu_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 32;
    localparam int unsigned DEFAULT_STAGES = 4;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } sub_mode_e;

endpackage

// File: rtl/adder_slice.sv
// One SLICE_W-bit ripple slice of the pipelined adder: {cout, sum} = a + b + cin.
module adder_slice #(
    parameter int unsigned SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
    assign sum    = w_full[SLICE_W-1:0];
    assign cout   = w_full[SLICE_W];

endmodule

// File: rtl/pipelined_adder.sv
// STAGES-deep add/sub pipeline, one WIDTH/STAGES slice per stage, valid/ready with bubble collapsing.
// Define PIPELINED_ADDER_OVF_EN to register the signed-overflow flag; otherwise overflow is tied low.
module pipelined_adder
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned SW   = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    sub_mode_e        w_mode;
    logic [WIDTH-1:0] w_b_eff;

    // Per stage: unprocessed upper operand bits (shifted down), partial sum, slice carry.
    logic [WIDTH-1:0]  r_ua  [STAGES];
    logic [WIDTH-1:0]  r_ub  [STAGES];
    logic [WIDTH-1:0]  r_sum [STAGES];
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_c;
    logic              r_zero;

    logic [WIDTH-1:0]  w_ain  [STAGES];
    logic [WIDTH-1:0]  w_bin  [STAGES];
    logic [WIDTH-1:0]  w_sin  [STAGES];
    logic [WIDTH-1:0]  w_nsum [STAGES];
    logic [SW-1:0]     w_ssum [STAGES];
    logic [STAGES-1:0] w_cin;
    logic [STAGES-1:0] w_cout;
    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_load;

    assign w_mode  = sub_mode_e'(sub);
    assign w_b_eff = (w_mode == MODE_SUB) ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_ain[k] = a;
            assign w_bin[k] = w_b_eff;
            assign w_sin[k] = '0;
            assign w_cin[k] = sub;
        end else begin : g_next
            assign w_ain[k] = r_ua[k-1];
            assign w_bin[k] = r_ub[k-1];
            assign w_sin[k] = r_sum[k-1];
            assign w_cin[k] = r_c[k-1];
        end

        adder_slice #(.SLICE_W(SW)) u_slice (
            .a    (w_ain[k][SW-1:0]),
            .b    (w_bin[k][SW-1:0]),
            .cin  (w_cin[k]),
            .sum  (w_ssum[k]),
            .cout (w_cout[k])
        );

        assign w_nsum[k] = w_sin[k] | (WIDTH'(w_ssum[k]) << (k * SW));
    end

    // Advance decisions resolve from the output stage backwards so a draining
    // tail lets every upstream stage move in the same cycle.
    always_comb begin
        w_adv  = '0;
        w_load = '0;
        for (int unsigned i = STAGES; i > 0; i--) begin
            if (i == STAGES)
                w_adv[i-1] = r_valid[i-1] && out_ready;
            else
                w_adv[i-1] = r_valid[i-1] && (!r_valid[i] || w_adv[i]);
        end
        in_ready  = !r_valid[0] || w_adv[0];
        w_load[0] = in_valid && in_ready;
        for (int unsigned i = 1; i < STAGES; i++)
            w_load[i] = w_adv[i-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_c     <= '0;
            r_zero  <= 1'b0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_ua[i]  <= '0;
                r_ub[i]  <= '0;
                r_sum[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                if (w_load[i]) begin
                    r_valid[i] <= 1'b1;
                    r_ua[i]    <= w_ain[i] >> SW;
                    r_ub[i]    <= w_bin[i] >> SW;
                    r_sum[i]   <= w_nsum[i];
                    r_c[i]     <= w_cout[i];
                end else if (w_adv[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
            if (w_load[LAST])
                r_zero <= (w_nsum[LAST] == '0);
        end
    end

`ifdef PIPELINED_ADDER_OVF_EN
    // The operand sign bits arrive with the top slice, so overflow is resolved in the last stage.
    logic r_ovf;
    logic w_ovf_next;

    assign w_ovf_next = (w_ain[LAST][SW-1] == w_bin[LAST][SW-1]) &&
                        (w_ssum[LAST][SW-1] != w_ain[LAST][SW-1]);

    always_ff @(posedge clk) begin
        if (reset)
            r_ovf <= 1'b0;
        else if (w_load[LAST])
            r_ovf <= w_ovf_next;
    end

    assign overflow = r_ovf;
`else
    assign overflow = 1'b0;
`endif

    assign out_valid = r_valid[LAST];
    assign sum       = r_sum[LAST];
    assign carry_out = r_c[LAST];
    assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and scoreboarded checks of pipelined_adder at 32/4 and 16/2 geometries.
module tb_pipelined_adder;

`ifdef PIPELINED_ADDER_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        d0_in_valid, d0_in_ready, d0_sub, d0_out_valid, d0_out_ready;
    logic        d0_carry, d0_ovf, d0_zero;
    logic [31:0] d0_a, d0_b, d0_sum;

    logic        d1_in_valid, d1_in_ready, d1_sub, d1_out_valid, d1_out_ready;
    logic        d1_carry, d1_ovf, d1_zero;
    logic [15:0] d1_a, d1_b, d1_sum;

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(d0_in_valid), .in_ready(d0_in_ready),
        .a(d0_a), .b(d0_b), .sub(d0_sub),
        .out_valid(d0_out_valid), .out_ready(d0_out_ready),
        .sum(d0_sum), .carry_out(d0_carry), .overflow(d0_ovf), .zero(d0_zero)
    );

    pipelined_adder #(.WIDTH(16), .STAGES(2)) dut16 (
        .clk(clk), .reset(reset),
        .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .a(d1_a), .b(d1_b), .sub(d1_sub),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready),
        .sum(d1_sum), .carry_out(d1_carry), .overflow(d1_ovf), .zero(d1_zero)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // Returns {carry, overflow, zero, sum} for a w-bit add/sub.
    function automatic logic [34:0] model(input logic [31:0] va, input logic [31:0] vb,
                                          input logic vs, input int w);
        logic [32:0] mask33, full;
        logic [31:0] mask, aa, be, sm;
        logic        c, v, z;
        mask33 = (33'd1 << w) - 33'd1;
        mask   = mask33[31:0];
        aa     = va & mask;
        be     = (vs ? ~vb : vb) & mask;
        full   = {1'b0, aa} + {1'b0, be} + {32'd0, vs};
        c      = full[w];
        sm     = full[31:0] & mask;
        v      = OVF_ON && (aa[w-1] == be[w-1]) && (sm[w-1] != aa[w-1]);
        z      = (sm == 32'd0);
        return {c, v, z, sm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                          input logic vs, input logic [31:0] es, input logic ec,
                          input logic ev, input logic ez);
        int lat;
        d0_a = va; d0_b = vb; d0_sub = vs; d0_in_valid = 1'b1; d0_out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(d0_in_ready), 64'd1);
        step();
        d0_in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!d0_out_valid && lat < 20) begin
            step();
            lat++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_sum"},   64'(d0_sum),   64'(es));
        check({tag, "_carry"}, 64'(d0_carry), 64'(ec));
        check({tag, "_ovf"},   64'(d0_ovf),   64'(ev && OVF_ON));
        check({tag, "_zero"},  64'(d0_zero),  64'(ez));
        step();
    endtask

    logic [31:0] bp_a [8];
    logic [31:0] bp_b [8];
    logic        bp_s [8];
    logic [34:0] bp_exp [8];
    logic [34:0] q [$];

    initial begin
        int sent, got, stale, n_out, cyc;
        logic prev_stalled, acc;
        logic [34:0] prev_out, e;

        reset = 1'b1;
        d0_in_valid = 1'b0; d0_a = '0; d0_b = '0; d0_sub = 1'b0; d0_out_ready = 1'b1;
        d1_in_valid = 1'b0; d1_a = '0; d1_b = '0; d1_sub = 1'b0; d1_out_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        check("rst_out_valid", 64'(d0_out_valid), 64'd0);
        check("rst_in_ready",  64'(d0_in_ready),  64'd1);
        check("rst_sum",       64'(d0_sum),       64'd0);
        check("rst_carry",     64'(d0_carry),     64'd0);
        check("rst_ovf",       64'(d0_ovf),       64'd0);
        check("rst_zero",      64'(d0_zero),      64'd0);
        check("rst16_out_valid", 64'(d1_out_valid), 64'd0);
        check("rst16_in_ready",  64'(d1_in_ready),  64'd1);
        reset = 1'b0;
        step();

        run_op("ff_add",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
        run_op("ovf_add",  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        run_op("sub_zero", 32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
        run_op("sub_brw",  32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        run_op("ovf_sub",  32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        run_op("mix_add",  32'h12345678, 32'h0F0F0F0F, 1'b0, 32'h21436587, 1'b0, 1'b0, 1'b0);

        // Eight back-to-back operands with the consumer stalled for cycles 3..7.
        for (int i = 0; i < 8; i++) begin
            bp_a[i]   = 32'h10000001 * (i + 1);
            bp_b[i]   = 32'hF0000000 + 32'(i * 3);
            bp_s[i]   = i[0];
            bp_exp[i] = model(bp_a[i], bp_b[i], bp_s[i], 32);
        end
        sent = 0; got = 0; prev_stalled = 1'b0; prev_out = '0;
        for (int c = 0; c < 40; c++) begin
            d0_in_valid = (sent < 8);
            if (sent < 8) begin
                d0_a = bp_a[sent]; d0_b = bp_b[sent]; d0_sub = bp_s[sent];
            end
            d0_out_ready = !(c >= 3 && c <= 7);
            @(negedge clk);
            if (c == 4)
                check("bp_in_ready_full", 64'(d0_in_ready), 64'd0);
            if (prev_stalled)
                check("bp_hold", 64'({d0_carry, d0_ovf, d0_zero, d0_sum}), 64'(prev_out));
            if (d0_out_valid && d0_out_ready) begin
                if (got < 8)
                    check($sformatf("bp_res%0d", got),
                          64'({d0_carry, d0_ovf, d0_zero, d0_sum}), 64'(bp_exp[got]));
                else
                    check("bp_extra_out", 64'(d0_out_valid), 64'd0);
                got++;
            end
            prev_stalled = d0_out_valid && !d0_out_ready;
            prev_out     = {d0_carry, d0_ovf, d0_zero, d0_sum};
            if (d0_in_valid && d0_in_ready)
                sent++;
            step();
        end
        check("bp_count", 64'(got), 64'd8);
        d0_in_valid = 1'b0;
        d0_out_ready = 1'b1;

        // Three operations in flight when reset hits.
        for (int i = 0; i < 3; i++) begin
            d0_in_valid = 1'b1;
            d0_a = 32'(i + 1); d0_b = 32'(i + 7); d0_sub = 1'b0;
            step();
        end
        d0_in_valid = 1'b0;
        reset = 1'b1;
        step();
        @(negedge clk);
        check("midrst_out_valid", 64'(d0_out_valid), 64'd0);
        check("midrst_in_ready",  64'(d0_in_ready),  64'd1);
        reset = 1'b0;
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            @(negedge clk);
            if (d0_out_valid)
                stale++;
        end
        check("midrst_stale", 64'(stale), 64'd0);
        step();

        // 16/2 instance under random traffic and backpressure.
        n_out = 0; cyc = 0; acc = 1'b0;
        while (n_out < 1000 && cyc < 20000) begin
            if (!d1_in_valid || acc) begin
                d1_in_valid = ($urandom_range(0, 9) < 7);
                d1_a   = 16'($urandom);
                d1_b   = 16'($urandom);
                d1_sub = 1'($urandom);
            end
            d1_out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            acc = d1_in_valid && d1_in_ready;
            if (acc)
                q.push_back(model({16'h0, d1_a}, {16'h0, d1_b}, d1_sub, 16));
            if (d1_out_valid && d1_out_ready) begin
                if (q.size() == 0) begin
                    check("rnd_unexpected", 64'(d1_out_valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    check("rnd_result",
                          64'({d1_carry, d1_ovf, d1_zero, 16'h0, d1_sum}), 64'(e));
                end
                n_out++;
            end
            step();
            cyc++;
        end
        check("rnd_count", 64'(n_out), 64'd1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
